// File: rtl/mem_stage_if.sv
// mem_stage_if -- data-memory request bus between the MEM pipeline stage and
// the data memory.
//
// Signals:
//   dmem_req    master->slave  request outstanding
//   dmem_we     master->slave  request is a store (only meaningful with dmem_req)
//   dmem_addr   master->slave  word address / effective address
//   dmem_wdata  master->slave  store data
//   dmem_ack    slave->master  memory completes the request this cycle
//   dmem_rdata  slave->master  load data, valid while dmem_ack is high
//
// Handshake: the master raises dmem_req with address, data and write-enable
// and holds all of them stable until the cycle in which the slave drives
// dmem_ack high; that cycle completes the transfer (read data is taken from
// dmem_rdata in the same cycle) and dmem_req drops at the following edge.
// The master may also withdraw a request that is never acknowledged
// (timeout or reset). An ack while dmem_req is low has no meaning.
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_ack,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage -- MEM pipeline stage with a variable-latency data-memory port.
//
// A load or store in the EX/MEM register stalls the upstream pipeline while a
// request is outstanding on the data-memory bus. Non-memory instructions pass
// to MEM/WB with one cycle of latency. A request that is not acknowledged
// within TIMEOUT wait cycles is aborted: the instruction retires without a
// register write and bus_err pulses.
//
// Parameter:
//   TIMEOUT        maximum WAIT cycles without ack before abort (2..255)
//
// Build option:
//   MEM_ALIGN_CHECK_EN  when defined, a memory op whose address has nonzero
//                       bits [1:0] issues no request, retires at once without
//                       a register write, and pulses align_err. When undefined
//                       the address is passed through and align_err is 0.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ex_*                     EX/MEM register contents (held upstream while stalled)
//   mem_stall                upstream hold request (combinational)
//   dmem                     data-memory bus (master side)
//   wb_valid, wb_reg_write   MEM/WB valid and register-file write enable
//   wb_rd, wb_data           MEM/WB destination and data
//   bus_err, align_err       one-cycle error pulses, aligned with the retiring wb
//   dbgState                 FSM state (0 = IDLE, 1 = WAIT)
module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               ex_valid,
    input  logic               ex_mem_read,
    input  logic               ex_mem_write,
    input  logic               ex_reg_write,
    input  logic               ex_mem_to_reg,
    input  logic [31:0]        ex_alu_result,
    input  logic [31:0]        ex_write_data,
    input  logic [4:0]         ex_rd,

    output logic               mem_stall,

    mem_stage_if.master        dmem,

    output logic               wb_valid,
    output logic               wb_reg_write,
    output logic [4:0]         wb_rd,
    output logic [31:0]        wb_data,
    output logic               bus_err,
    output logic               align_err,

    output logic               dbgState
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Counter value of the last WAIT cycle allowed before abort.
    localparam logic [7:0] lastWait = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     stateNext;
    logic [7:0] waitCnt;

    logic memop;
    logic misaligned;
    logic ackHit;
    logic timeoutHit;

    assign memop = ex_valid & (ex_mem_read | ex_mem_write);

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = memop & (ex_alu_result[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // An ack arriving on the last allowed cycle wins over the timeout.
    assign ackHit     = (state == WAIT) & dmem.dmem_ack;
    assign timeoutHit = (state == WAIT) & ~dmem.dmem_ack & (waitCnt == lastWait);

    assign dbgState = (state == WAIT);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        stateNext = state;
        if (state == IDLE) begin
            if (memop && !misaligned) begin
                stateNext = WAIT;
            end
        end else begin
            if (ackHit || timeoutHit) begin
                stateNext = IDLE;
            end
        end
    end

    // -------------------------------------------------------------- outputs
    // The stall drops in the completing cycle (ack or abort) so that the
    // upstream advances on the same edge that retires the instruction.
    always_comb begin
        mem_stall = 1'b0;
        if (!rst) begin
            if (state == IDLE) begin
                mem_stall = memop & ~misaligned;
            end else begin
                mem_stall = ~dmem.dmem_ack & ~timeoutHit;
            end
        end
    end

    // ---------------------------------------------------------- wait counter
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            waitCnt <= 8'd0;
        end else if (!dmem.dmem_ack) begin
            waitCnt <= waitCnt + 8'd1;
        end
    end

    // -------------------------------------------- request and MEM/WB registers
    always_ff @(posedge clk) begin
        if (rst) begin
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= 32'd0;
            dmem.dmem_wdata <= 32'd0;
            wb_valid        <= 1'b0;
            wb_reg_write    <= 1'b0;
            wb_rd           <= 5'd0;
            wb_data         <= 32'd0;
            bus_err         <= 1'b0;
            align_err       <= 1'b0;
        end else begin
            bus_err   <= 1'b0;
            align_err <= 1'b0;
            if (state == IDLE) begin
                if (memop && !misaligned) begin
                    dmem.dmem_req   <= 1'b1;
                    dmem.dmem_we    <= ex_mem_write;
                    dmem.dmem_addr  <= ex_alu_result;
                    dmem.dmem_wdata <= ex_write_data;
                    wb_valid        <= 1'b0;
                    wb_reg_write    <= 1'b0;
                end else if (misaligned) begin
                    wb_valid     <= 1'b1;
                    wb_reg_write <= 1'b0;
                    wb_rd        <= ex_rd;
                    wb_data      <= ex_alu_result;
                    align_err    <= 1'b1;
                end else begin
                    wb_valid     <= ex_valid;
                    wb_reg_write <= ex_valid & ex_reg_write;
                    wb_rd        <= ex_rd;
                    wb_data      <= ex_alu_result;
                end
            end else begin
                if (ackHit) begin
                    dmem.dmem_req <= 1'b0;
                    dmem.dmem_we  <= 1'b0;
                    wb_valid      <= 1'b1;
                    wb_reg_write  <= ex_reg_write;
                    wb_rd         <= ex_rd;
                    wb_data       <= ex_mem_to_reg ? dmem.dmem_rdata : ex_alu_result;
                end else if (timeoutHit) begin
                    dmem.dmem_req <= 1'b0;
                    dmem.dmem_we  <= 1'b0;
                    wb_valid      <= 1'b1;
                    wb_reg_write  <= 1'b0;
                    wb_rd         <= ex_rd;
                    wb_data       <= ex_alu_result;
                    bus_err       <= 1'b1;
                end else begin
                    wb_valid     <= 1'b0;
                    wb_reg_write <= 1'b0;
                end
            end
        end
    end

endmodule
